// File: rtl/vend_pkg.sv
// Shared coin values, money width and dispenser state encoding for the
// vending machine and change dispenser.
package vend_pkg;

  localparam int MONEY_W = 8;

  localparam logic [MONEY_W-1:0] COIN_HI = 8'd10;
  localparam logic [MONEY_W-1:0] COIN_LO = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } disp_state_e;

endpackage

// File: rtl/vend_coin_inv.sv
// Saturating up/down coin inventory counter. A refill and a dispense in the
// same cycle cancel out.
module vend_coin_inv #(
  parameter int               INV_W = 8,
  parameter logic [INV_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [INV_W-1:0] cnt
);

  localparam logic [INV_W-1:0] CNT_ONE = {{(INV_W-1){1'b0}}, 1'b1};
  localparam logic [INV_W-1:0] CNT_MAX = {INV_W{1'b1}};

  logic [INV_W-1:0] cnt_q;
  logic [INV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout controller: large coins first, then small coins, one
// eject/done handshake with the hopper per coin, with jam timeout.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | waiting for a payout request
//   ST_SELECT   | choose next coin from remaining amount and inventory
//   ST_WAIT_ACK | coin commanded, waiting for hopper_done or timeout
//   ST_DONE     | report shortfall, pulse done, release busy
//   ST_FAULT    | hopper jammed, held until clear_fault
module change_dispenser
  import vend_pkg::*;
#(
  parameter int INV_W       = 8,
  parameter int INV_HI_INIT = 20,
  parameter int INV_LO_INIT = 20,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               change_valid,
  input  logic [MONEY_W-1:0] change_amt,
  input  logic               hopper_done,
  input  logic               refill_hi,
  input  logic               refill_lo,
  input  logic               clear_fault,
  output logic               busy,
  output logic               eject_hi,
  output logic               eject_lo,
  output logic               done,
  output logic [MONEY_W-1:0] paid,
  output logic [MONEY_W-1:0] shortfall,
  output logic               jam,
  output logic [INV_W-1:0]   inv_hi,
  output logic [INV_W-1:0]   inv_lo
);

  localparam int                 TIMER_W   = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TIMER_TC  = TIMER_W'(TIMEOUT - 1);

  disp_state_e        state_q, state_d;
  logic [MONEY_W-1:0] remaining_q, remaining_d;
  logic [MONEY_W-1:0] paid_q, paid_d;
  logic [MONEY_W-1:0] shortfall_q, shortfall_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               eject_hi_q, eject_hi_d;
  logic               eject_lo_q, eject_lo_d;
  logic               done_q, done_d;
  logic               jam_q, jam_d;
  logic               coin_hi_q, coin_hi_d;

  logic               coin_ack;
  logic [MONEY_W-1:0] coin_val;
  logic [INV_W-1:0]   inv_hi_cnt;
  logic [INV_W-1:0]   inv_lo_cnt;

  // A coin is only debited once the hopper confirms it left the machine.
  assign coin_ack = (state_q == ST_WAIT_ACK) && hopper_done;
  assign coin_val = coin_hi_q ? COIN_HI : COIN_LO;

  vend_coin_inv #(
    .INV_W (INV_W),
    .INIT  (INV_W'(INV_HI_INIT))
  ) u_inv_hi (
    .clk (clk),
    .rst (rst),
    .inc (refill_hi),
    .dec (coin_ack && coin_hi_q),
    .cnt (inv_hi_cnt)
  );

  vend_coin_inv #(
    .INV_W (INV_W),
    .INIT  (INV_W'(INV_LO_INIT))
  ) u_inv_lo (
    .clk (clk),
    .rst (rst),
    .inc (refill_lo),
    .dec (coin_ack && !coin_hi_q),
    .cnt (inv_lo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    paid_d      = paid_q;
    shortfall_d = shortfall_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    eject_hi_d  = 1'b0;
    eject_lo_d  = 1'b0;
    done_d      = 1'b0;
    jam_d       = jam_q;
    coin_hi_d   = coin_hi_q;

    case (state_q)
      ST_IDLE: begin
        if (change_valid) begin
          remaining_d = change_amt;
          paid_d      = '0;
          shortfall_d = '0;
          busy_d      = 1'b1;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        timer_d = '0;
        if ((remaining_q >= COIN_HI) && (inv_hi_cnt != '0)) begin
          eject_hi_d = 1'b1;
          coin_hi_d  = 1'b1;
          state_d    = ST_WAIT_ACK;
        end else if ((remaining_q >= COIN_LO) && (inv_lo_cnt != '0)) begin
          eject_lo_d = 1'b1;
          coin_hi_d  = 1'b0;
          state_d    = ST_WAIT_ACK;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_ACK: begin
        if (hopper_done) begin
          remaining_d = remaining_q - coin_val;
          paid_d      = paid_q + coin_val;
          timer_d     = '0;
          state_d     = ST_SELECT;
        end else if (timer_q == TIMER_TC) begin
          // The coin in flight is never credited: its fate is unknown.
          jam_d   = 1'b1;
          timer_d = '0;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          jam_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        shortfall_d = remaining_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      paid_q      <= '0;
      shortfall_q <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      eject_hi_q  <= 1'b0;
      eject_lo_q  <= 1'b0;
      done_q      <= 1'b0;
      jam_q       <= 1'b0;
      coin_hi_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      paid_q      <= paid_d;
      shortfall_q <= shortfall_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      eject_hi_q  <= eject_hi_d;
      eject_lo_q  <= eject_lo_d;
      done_q      <= done_d;
      jam_q       <= jam_d;
      coin_hi_q   <= coin_hi_d;
    end
  end

  assign busy      = busy_q;
  assign eject_hi  = eject_hi_q;
  assign eject_lo  = eject_lo_q;
  assign done      = done_q;
  assign paid      = paid_q;
  assign shortfall = shortfall_q;
  assign jam       = jam_q;
  assign inv_hi    = inv_hi_cnt;
  assign inv_lo    = inv_lo_cnt;

endmodule
